// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: accepts words over valid/ready and drives them one bit
// per clock onto a shift register's serial input, with a one-word hold buffer.
//
// state    | meaning
// ST_IDLE  | no word in the shifter, waiting for one
// ST_SHIFT | driving bit_cnt of the current word onto SI
// ST_GAP   | idle clocks between two consecutive words
module serial_word_feeder #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             SI,
  output logic             mode,
  output logic             sh_en,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             dir_r;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_dir;
  logic             hold_full;

  logic             accept;
  logic             avail;
  logic             last_bit;
  logic             gap_end;
  logic             load;
  logic             hold_full_nxt;
  logic [WIDTH-1:0] next_data;
  logic             next_dir;

  assign in_ready  = !rst && !hold_full;
  assign accept    = in_valid && in_ready;
  assign avail     = hold_full || accept;
  // The hold buffer always holds the older word, so it has priority at a load.
  assign next_data = hold_full ? hold_data : in_data;
  assign next_dir  = hold_full ? hold_dir  : in_dir;
  assign last_bit  = (state == ST_SHIFT) && (bit_cnt == LAST_BIT);
  assign gap_end   = (state == ST_GAP) && (gap_cnt == 4'd0);
  assign load      = avail && ((state == ST_IDLE) || (last_bit && GAP == 0) || gap_end);
  assign hold_full_nxt = load ? (hold_full && accept) : (hold_full || accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      dir_r     <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= 4'd0;
      hold_data <= '0;
      hold_dir  <= 1'b0;
      hold_full <= 1'b0;
      SI        <= 1'b0;
      mode      <= 1'b0;
      sh_en     <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (accept && (hold_full || !load)) begin
        hold_data <= in_data;
        hold_dir  <= in_dir;
      end
      hold_full <= hold_full_nxt;
      word_done <= 1'b0;
      busy      <= hold_full_nxt || load ||
                   ((state == ST_SHIFT) && (!last_bit || avail)) ||
                   ((state == ST_GAP) && !gap_end);

      if (load) begin
        state   <= ST_SHIFT;
        shreg   <= next_data;
        dir_r   <= next_dir;
        mode    <= next_dir;
        bit_cnt <= '0;
        sh_en   <= 1'b1;
        SI      <= next_dir ? next_data[0] : next_data[WIDTH-1];
      end else begin
        case (state)
          ST_SHIFT: begin
            if (last_bit) begin
              sh_en <= 1'b0;
              SI    <= 1'b0;
              if (avail) begin
                state   <= ST_GAP;
                gap_cnt <= 4'(GAP - 1);
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shreg     <= dir_r ? (shreg >> 1) : (shreg << 1);
              SI        <= dir_r ? shreg[1] : shreg[WIDTH-2];
              word_done <= (bit_cnt == PRE_LAST);
            end
          end
          ST_GAP: begin
            if (gap_cnt == 4'd0) state <= ST_IDLE;
            else gap_cnt <= gap_cnt - 4'd1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: a GAP=0 and a GAP=2 instance share one stimulus and
// are each compared every cycle against a queue-based word-stream model.
module tb_serial_word_feeder;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_dir;
  logic         in_valid;
  logic [1:0]   rdy, si, md, en, wd, bz;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  serial_word_feeder #(.WIDTH(W), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_dir(in_dir), .in_valid(in_valid),
    .in_ready(rdy[0]), .SI(si[0]), .mode(md[0]), .sh_en(en[0]),
    .word_done(wd[0]), .busy(bz[0]));

  serial_word_feeder #(.WIDTH(W), .GAP(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_dir(in_dir), .in_valid(in_valid),
    .in_ready(rdy[1]), .SI(si[1]), .mode(md[1]), .sh_en(en[1]),
    .word_done(wd[1]), .busy(bz[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Reference model: words waiting to start, the word on the wire, and idle clocks left.
  int           gaps [2] = '{0, 2};
  logic [W:0]   q    [2][$];
  logic [W-1:0] cw   [2];
  logic         cd   [2];
  logic         cv   [2];
  logic         mm   [2];
  int           pos  [2];
  int           gl   [2];

  task automatic start_word(input int i);
    logic [W:0] e;
    e = q[i].pop_front();
    cw[i] = e[W-1:0];
    cd[i] = e[W];
    mm[i] = e[W];
    pos[i] = 0;
    cv[i] = 1'b1;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        q[i].delete();
        cv[i] = 1'b0; gl[i] = 0; pos[i] = 0; mm[i] = 1'b0; cw[i] = '0; cd[i] = 1'b0;
      end else begin
        if (in_valid && q[i].size() == 0) q[i].push_back({in_dir, in_data});
        if (cv[i] && pos[i] < W - 1) pos[i]++;
        else if (cv[i]) begin
          cv[i] = 1'b0;
          if (q[i].size() > 0) begin
            if (gaps[i] == 0) start_word(i);
            else gl[i] = gaps[i];
          end
        end else if (gl[i] > 0) begin
          gl[i]--;
          if (gl[i] == 0 && q[i].size() > 0) start_word(i);
        end else if (q[i].size() > 0) start_word(i);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic exp_si;
        exp_si = cv[i] ? (cd[i] ? cw[i][pos[i]] : cw[i][W-1-pos[i]]) : 1'b0;
        chk($sformatf("in_ready%0d", i), rdy[i], !rst && q[i].size() == 0);
        chk($sformatf("sh_en%0d", i), en[i], cv[i]);
        chk($sformatf("SI%0d", i), si[i], exp_si);
        chk($sformatf("word_done%0d", i), wd[i], cv[i] && pos[i] == W - 1);
        chk($sformatf("mode%0d", i), md[i], mm[i]);
        chk($sformatf("busy%0d", i), bz[i], cv[i] || gl[i] > 0 || q[i].size() > 0);
      end
    end
  end

  // Capture of the serial stream for the directed scenarios.
  logic [31:0] sbits, dbits, e1;
  int          scnt, run, maxrun, e1cnt;
  always @(negedge clk) begin
    if (en[0]) begin
      sbits = {sbits[30:0], si[0]};
      dbits = {dbits[30:0], wd[0]};
      scnt++;
      run++;
      if (run > maxrun) maxrun = run;
    end else run = 0;
    if ((e1cnt > 0 || en[1]) && e1cnt < 10) begin
      e1 = {e1[30:0], en[1]};
      e1cnt++;
    end
  end

  task automatic clear_capture();
    sbits = '0; dbits = '0; e1 = '0;
    scnt = 0; run = 0; maxrun = 0; e1cnt = 0;
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic dr);
    @(negedge clk);
    #2;
    rst = r; in_valid = v; in_data = d; in_dir = dr;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    bit got;
    rst = 1'b1; in_valid = 1'b1; in_data = 4'hF; in_dir = 1'b0;
    clear_capture();
    @(posedge clk);
    chk_en = 1;
    // T1: reset held with valid high
    drive(1'b1, 1'b1, 4'hF, 1'b0);
    @(negedge clk);
    chk("t1_ready", rdy[0], 1'b0);
    chk("t1_busy", bz[0], 1'b0);
    #2 rst = 1'b0; in_valid = 1'b0;
    idle(2);

    // T2: MSB first
    clear_capture();
    drive(1'b0, 1'b1, 4'b1011, 1'b0);
    idle(7);
    chk("t2_bits", sbits[3:0], 4'b1011);
    chk("t2_done", dbits[3:0], 4'b0001);
    chk("t2_count", scnt, 4);

    // T3: LSB first
    clear_capture();
    drive(1'b0, 1'b1, 4'b1011, 1'b1);
    idle(7);
    chk("t3_bits", sbits[3:0], 4'b1101);
    chk("t3_count", scnt, 4);

    // T4: back-to-back through the hold buffer
    clear_capture();
    drive(1'b0, 1'b1, 4'hA, 1'b0);
    drive(1'b0, 1'b1, 4'h3, 1'b1);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      drive(1'b0, 1'b1, 4'hF, 1'b0);
      #1;
      got = rdy[0];
    end
    chk("t4_accept", got, 1'b1);
    idle(12);
    chk("t4_bits", sbits[11:0], 12'b1010_1100_1111);
    chk("t4_contig", maxrun, 12);

    // T5: reset in the middle of a word
    clear_capture();
    drive(1'b0, 1'b1, 4'b1100, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("t5_sh_en", en[0], 1'b0);
    chk("t5_busy", bz[0], 1'b0);
    #2 rst = 1'b0;
    idle(1);
    chk("t5_ready", rdy[0], 1'b1);
    chk("t5_bits", scnt, 2);
    chk("t5_no_done", dbits, 32'h0);
    idle(4);

    // T6: two idle cycles between words on the GAP=2 instance
    clear_capture();
    drive(1'b0, 1'b1, 4'h5, 1'b0);
    drive(1'b0, 1'b1, 4'h9, 1'b1);
    idle(16);
    chk("t6_gap", e1[9:0], 10'b1111001111);

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
            W'($urandom), 1'($urandom));
    end
    idle(12);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0d", 200000);
    $fatal(1);
  end

endmodule
